// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path (and the matching transmitter):
//   - uart_state_e : receiver FSM state encoding
//   - OVS          : oversample ticks per bit
//   - DATA_BITS    : payload width of one frame (8N1)
//   - MID_SAMPLE   : sample-counter value at the middle of the start bit
//   - END_SAMPLE   : sample-counter value at the last tick of a bit
//   - shift_in_msb : LSB-first shift helper for the receive shift register
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } uart_state_e;

   localparam int OVS       = 16;
   localparam int DATA_BITS = 8;

   localparam logic [3:0] MID_SAMPLE = 4'd7;
   localparam logic [3:0] END_SAMPLE = 4'd15;

   // Bits arrive LSB first, so each new bit enters at the MSB and the
   // first bit received ends up in bit 0 after DATA_BITS shifts.
   function automatic logic [DATA_BITS-1:0] shift_in_msb(
      input logic [DATA_BITS-1:0] sr,
      input logic                 din
   );
      shift_in_msb = {din, sr[DATA_BITS-1:1]};
   endfunction

endpackage : uart_pkg

// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if
// Serial-in / byte-out bundle of the UART receiver.
//   rx        : asynchronous serial line, idles high
//   dataout   : last correctly framed byte
//   Done      : one-clock strobe when dataout is updated
//   frame_err : one-clock strobe when a stop bit is sampled low
//   tick      : oversample tick (one clock wide every DIV clocks)
// Modports:
//   slave  - the receiver (consumes rx, produces the rest)
//   master - the line driver / byte consumer
// -----------------------------------------------------------------------------
interface uart_rx_if;
   import uart_pkg::*;

   logic                 rx;
   logic [DATA_BITS-1:0] dataout;
   logic                 Done;
   logic                 frame_err;
   logic                 tick;

   modport slave (
      input  rx,
      output dataout,
      output Done,
      output frame_err,
      output tick
   );

   modport master (
      output rx,
      input  dataout,
      input  Done,
      input  frame_err,
      input  tick
   );

endinterface : uart_rx_if

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Free-running oversample tick generator shared by the UART transmitter and
// receiver, so both ends derive the same bit rate from one divider.
// Parameters:
//   DIV     : clocks per tick (>= 1). DIV = 1 gives a tick that is held high.
// Ports:
//   i_clk   : clock, rising edge
//   i_reset : synchronous active-high reset
//   o_tick  : registered tick, one clock wide every DIV clocks; the first
//             tick appears DIV clocks after reset is released
// -----------------------------------------------------------------------------
module uart_baud_tick #(
   parameter int DIV = 4
) (
   input  logic i_clk,
   input  logic i_reset,
   output logic o_tick
);

   // A one-state divider still needs a 1-bit counter to stay legal.
   localparam int            W      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0]  L_WRAP = W'(DIV - 1);
   localparam logic [W-1:0]  L_ZERO = W'(0);
   localparam logic [W-1:0]  L_ONE  = W'(1);

   logic [W-1:0] r_cnt;
   logic         r_tick;

   // Modulo-DIV counter; the tick is registered on the wrap, never realigned.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cnt  <= L_ZERO;
         r_tick <= 1'b0;
      end else begin
         if (r_cnt == L_WRAP) begin
            r_cnt  <= L_ZERO;
            r_tick <= 1'b1;
         end else begin
            r_cnt  <= r_cnt + L_ONE;
            r_tick <= 1'b0;
         end
      end
   end

   assign o_tick = r_tick;

endmodule : uart_baud_tick

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver with 16x oversampling.
//   - rx is brought into the clock domain by a two-flop synchroniser (rx_s)
//   - a start bit is qualified at its middle; a high there is a glitch
//   - 8 data bits are sampled LSB first, one per 16 ticks
//   - the stop bit is sampled at 9.5 bits: high -> byte + Done,
//     low -> frame_err and wait in BREAK until the line returns high
// Parameters:
//   DIV   : clocks per oversample tick (>= 1); bit period = DIV*16 clocks
//   OVS   : oversample ticks per bit, fixed at 16
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high reset, aborts any frame in progress
//   bus   : uart_rx_if.slave (rx in; dataout, Done, frame_err, tick out)
// -----------------------------------------------------------------------------
module uart_rx #(
   parameter int DIV = 4,
   parameter int OVS = 16
) (
   input  logic     clk,
   input  logic     reset,
   uart_rx_if.slave bus
);
   import uart_pkg::*;

   localparam logic [2:0] S_IDLE  = ST_IDLE;
   localparam logic [2:0] S_START = ST_START;
   localparam logic [2:0] S_DATA  = ST_DATA;
   localparam logic [2:0] S_STOP  = ST_STOP;
   localparam logic [2:0] S_BREAK = ST_BREAK;

   localparam logic [3:0] L_END      = 4'(OVS - 1);
   localparam logic [2:0] L_LAST_BIT = 3'(DATA_BITS - 1);

   logic                 w_tick;

   logic                 r_sync1;
   logic                 r_sync2;

   logic [2:0]           r_state;
   logic [3:0]           r_sc;
   logic [2:0]           r_bc;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] r_dataout;
   logic                 r_done;
   logic                 r_ferr;

   logic [2:0]           w_state_nx;
   logic [3:0]           w_sc_nx;
   logic [2:0]           w_bc_nx;
   logic [DATA_BITS-1:0] w_shift_nx;
   logic [DATA_BITS-1:0] w_dataout_nx;
   logic                 w_done_nx;
   logic                 w_ferr_nx;

   uart_baud_tick #(
      .DIV (DIV)
   ) u_baud_tick (
      .i_clk   (clk),
      .i_reset (reset),
      .o_tick  (w_tick)
   );

   // Two-flop synchroniser; resets to the idle (high) line level so a reset
   // never looks like a start edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= bus.rx;
         r_sync2 <= r_sync1;
      end
   end

   // Next-state logic; everything advances only on an oversample tick.
   always_comb begin
      w_state_nx   = r_state;
      w_sc_nx      = r_sc;
      w_bc_nx      = r_bc;
      w_shift_nx   = r_shift;
      w_dataout_nx = r_dataout;
      w_done_nx    = 1'b0;
      w_ferr_nx    = 1'b0;

      if (w_tick) begin
         case (r_state)
            S_IDLE: begin
               // The detecting tick counts as sample 0 of the start bit.
               if (r_sync2 == 1'b0) begin
                  w_state_nx = S_START;
                  w_sc_nx    = 4'd1;
               end else begin
                  w_state_nx = S_IDLE;
                  w_sc_nx    = 4'd0;
               end
            end

            S_START: begin
               if (r_sc == MID_SAMPLE) begin
                  w_sc_nx = 4'd0;
                  if (r_sync2 == 1'b1) begin
                     // Line went back high before mid-bit: not a real start.
                     w_state_nx = S_IDLE;
                  end else begin
                     w_state_nx = S_DATA;
                     w_bc_nx    = 3'd0;
                  end
               end else begin
                  w_sc_nx = r_sc + 4'd1;
               end
            end

            S_DATA: begin
               // sc was cleared at mid start bit, so sc==END lands mid data bit.
               if (r_sc == L_END) begin
                  w_sc_nx    = 4'd0;
                  w_shift_nx = shift_in_msb(r_shift, r_sync2);
                  if (r_bc == L_LAST_BIT) begin
                     w_state_nx = S_STOP;
                     w_bc_nx    = 3'd0;
                  end else begin
                     w_bc_nx = r_bc + 3'd1;
                  end
               end else begin
                  w_sc_nx = r_sc + 4'd1;
               end
            end

            S_STOP: begin
               if (r_sc == L_END) begin
                  w_sc_nx = 4'd0;
                  if (r_sync2 == 1'b1) begin
                     w_dataout_nx = r_shift;
                     w_done_nx    = 1'b1;
                     w_state_nx   = S_IDLE;
                  end else begin
                     w_ferr_nx  = 1'b1;
                     w_state_nx = S_BREAK;
                  end
               end else begin
                  w_sc_nx = r_sc + 4'd1;
               end
            end

            S_BREAK: begin
               // Hold here while the line stays low so a break is not
               // decoded as a stream of 8'h00 frames.
               if (r_sync2 == 1'b1) begin
                  w_state_nx = S_IDLE;
               end else begin
                  w_state_nx = S_BREAK;
               end
            end

            default: begin
               w_state_nx = S_IDLE;
               w_sc_nx    = 4'd0;
               w_bc_nx    = 3'd0;
            end
         endcase
      end else begin
         w_state_nx = r_state;
      end
   end

   // State, counters, shift register and registered strobes.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_sc      <= 4'd0;
         r_bc      <= 3'd0;
         r_shift   <= 8'h00;
         r_dataout <= 8'h00;
         r_done    <= 1'b0;
         r_ferr    <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_sc      <= w_sc_nx;
         r_bc      <= w_bc_nx;
         r_shift   <= w_shift_nx;
         r_dataout <= w_dataout_nx;
         r_done    <= w_done_nx;
         r_ferr    <= w_ferr_nx;
      end
   end

   assign bus.dataout   = r_dataout;
   assign bus.Done      = r_done;
   assign bus.frame_err = r_ferr;
   assign bus.tick      = w_tick;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx. Two receivers are built: one with DIV=4
// (64 clocks per bit) and one with DIV=1. The bench drives 8N1 frames, glitches
// and low stop bits onto rx, and a reference model records what each frame must
// produce (byte + Done, or frame_err) and the window in which it must appear.
// One compare process checks tick, dataout and the strobes on every cycle.
// -----------------------------------------------------------------------------
module tb_uart_rx;

   localparam int DIV_A = 4;
   localparam int DIV_B = 1;

   typedef struct {
      bit         err;
      logic [7:0] data;
      int         t0;
   } ev_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   ev_t q_a[$];
   ev_t q_b[$];

   uart_rx_if if_a ();
   uart_rx_if if_b ();

   uart_rx #(.DIV(DIV_A), .OVS(16)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (if_a)
   );

   uart_rx #(.DIV(DIV_B), .OVS(16)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (if_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #800000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model + compare ----------------
   logic       rst_d = 1'b1;
   int         k     = 0;       // clock edges since reset was last sampled high
   logic [7:0] exp_a = 8'h00;
   logic [7:0] exp_b = 8'h00;

   task automatic check_event(input string tag, input int div, input logic done,
                              input logic ferr, inout ev_t q[$], inout logic [7:0] expd);
      ev_t ev;
      int  lat;
      check({tag, "_done_ferr_exclusive"}, {31'd0, done & ferr}, 32'd0);
      n_checks++;
      if (q.size() == 0) begin
         n_fail++;
         $display("FAIL %s_unexpected_event: got Done=%0b frame_err=%0b, expected no event", tag, done, ferr);
      end else begin
         n_fail = n_fail - 0;
         ev  = q.pop_front();
         lat = cyc - ev.t0;
         check({tag, "_event_kind"}, {31'd0, ferr}, {31'd0, ev.err});
         n_checks++;
         if (lat < 152*div - div + 3 || lat > 152*div + div + 3) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d clocks, expected %0d..%0d", tag, lat,
                     152*div - div + 3, 152*div + div + 3);
         end
         if (!ev.err) expd = ev.data;
      end
   endtask

   always @(negedge clk) begin
      // rst_d is the reset value the DUT sampled on the edge just passed.
      if (rst_d) begin
         k     = 0;
         exp_a = 8'h00;
         exp_b = 8'h00;
         q_a.delete();
         q_b.delete();
      end else begin
         k = k + 1;
      end
      rst_d = reset;

      check("tick_a", {31'd0, if_a.tick}, {31'd0, (k > 0) && ((k % DIV_A) == 0)});
      check("tick_b", {31'd0, if_b.tick}, {31'd0, (k > 0)});

      if (if_a.Done || if_a.frame_err)
         check_event("a", DIV_A, if_a.Done, if_a.frame_err, q_a, exp_a);
      if (if_b.Done || if_b.frame_err)
         check_event("b", DIV_B, if_b.Done, if_b.frame_err, q_b, exp_b);

      check("dataout_a", {24'd0, if_a.dataout}, {24'd0, exp_a});
      check("dataout_b", {24'd0, if_b.dataout}, {24'd0, exp_b});
   end

   // ---------------- stimulus helpers ----------------
   // Called just after a rising edge; holds the level for n clocks.
   task automatic drive(input int which, input logic v, input int n);
      if (which == 0) if_a.rx = v;
      else            if_b.rx = v;
      if (n > 0) begin
         repeat (n) @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input int which, input int div, input logic [7:0] b,
                       input bit stop_ok, input int gap);
      ev_t ev;
      ev.err  = !stop_ok;
      ev.data = b;
      ev.t0   = cyc;
      if (which == 0) q_a.push_back(ev);
      else            q_b.push_back(ev);
      drive(which, 1'b0, 16*div);
      for (int i = 0; i < 8; i++) drive(which, b[i], 16*div);
      if (stop_ok) drive(which, 1'b1, 16*div);
      else         drive(which, 1'b0, 32*div);
      drive(which, 1'b1, gap);
   endtask

   task automatic drain(input int budget);
      int t;
      t = 0;
      while ((q_a.size() != 0 || q_b.size() != 0) && t < budget) begin
         @(posedge clk);
         #1;
         t++;
      end
      n_checks++;
      if (q_a.size() != 0 || q_b.size() != 0) begin
         n_fail++;
         $display("FAIL drain_timeout: got %0d pending events after %0d cycles, expected 0",
                  q_a.size() + q_b.size(), budget);
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int kind;
      int gap;
      logic [7:0] b;

      if_a.rx = 1'b1;
      if_b.rx = 1'b1;
      reset   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_dataout", {24'd0, if_a.dataout}, 32'h0000_0000);
      check("reset_done",    {31'd0, if_a.Done},      32'd0);
      check("reset_ferr",    {31'd0, if_a.frame_err}, 32'd0);
      check("reset_tick",    {31'd0, if_a.tick},      32'd0);
      reset = 1'b0;
      drive(0, 1'b1, 20);

      // Single frame 8'b10110011.
      send(0, DIV_A, 8'b1011_0011, 1'b1, 20);
      drain(2000);
      check("pin_first_byte", {24'd0, if_a.dataout}, 32'h0000_00B3);

      // Back-to-back frames, no idle gap between them.
      send(0, DIV_A, 8'hB3, 1'b1, 0);
      send(0, DIV_A, 8'hCC, 1'b1, 20);
      drain(2000);
      check("pin_back_to_back", {24'd0, if_a.dataout}, 32'h0000_00CC);

      // Short glitch: must be rejected at mid start bit.
      drive(0, 1'b0, 3*DIV_A);
      drive(0, 1'b1, 16*DIV_A);
      check("pin_after_glitch", {24'd0, if_a.dataout}, 32'h0000_00CC);

      // Framing error with the line held low, then a good frame.
      send(0, DIV_A, 8'h55, 1'b0, 16*DIV_A);
      drain(2000);
      check("pin_ferr_keeps", {24'd0, if_a.dataout}, 32'h0000_00CC);
      send(0, DIV_A, 8'hA5, 1'b1, 20);
      drain(2000);
      check("pin_after_ferr", {24'd0, if_a.dataout}, 32'h0000_00A5);

      // Reset for one clock after bit 3 of 8'hFF; the rest of the frame is high.
      drive(0, 1'b0, 16*DIV_A);
      drive(0, 1'b1, 4*16*DIV_A);
      reset = 1'b1;
      drive(0, 1'b1, 1);
      reset = 1'b0;
      drive(0, 1'b1, 5*16*DIV_A);
      check("pin_reset_midframe", {24'd0, if_a.dataout}, 32'h0000_0000);
      send(0, DIV_A, 8'h3C, 1'b1, 20);
      drain(2000);
      check("pin_after_reset", {24'd0, if_a.dataout}, 32'h0000_003C);

      // Randomized mix of good frames, framing errors and glitches.
      for (int r = 0; r < 30; r++) begin
         kind = $urandom_range(0, 9);
         b    = 8'($urandom);
         if (kind <= 5) begin
            gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 40);
            send(0, DIV_A, b, 1'b1, gap);
         end else if (kind <= 7) begin
            send(0, DIV_A, b, 1'b0, 16*DIV_A + $urandom_range(0, 20));
         end else begin
            drive(0, 1'b0, $urandom_range(1, 6*DIV_A));
            drive(0, 1'b1, 16*DIV_A);
         end
      end
      drain(2000);

      // DIV=1 receiver.
      send(1, DIV_B, 8'h81, 1'b1, 16);
      drain(500);
      check("pin_div1_byte", {24'd0, if_b.dataout}, 32'h0000_0081);

      drive(0, 1'b1, 10);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_uart_rx
